// File: rtl/apb_master_mc_if.sv
// Command/response port and multi-slave APB bus of apb_master_mc, bundled as one interface.
// The master modport is the controller's view; the slave modport is the command source and slaves.
interface apb_master_mc_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic                         cmd_write;
    logic [ADDR_W-1:0]            cmd_addr;
    logic [DATA_W-1:0]            cmd_wdata;
    logic [DATA_W/8-1:0]          cmd_strb;
    logic [2:0]                   cmd_prot;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;
    logic                         rsp_timeout;
    logic [NUM_SLAVES-1:0]        Psel;
    logic                         Penable;
    logic [ADDR_W-1:0]            Paddr;
    logic                         Pwrite;
    logic [DATA_W-1:0]            Pwdata;
    logic [DATA_W/8-1:0]          Pstrb;
    logic [2:0]                   Pprot;
    logic [NUM_SLAVES*DATA_W-1:0] Prdata;
    logic [NUM_SLAVES-1:0]        Pready;
    logic [NUM_SLAVES-1:0]        Pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  Prdata, Pready, Pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output Psel, Penable, Paddr, Pwrite, Pwdata, Pstrb, Pprot
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output Prdata, Pready, Pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  Psel, Penable, Paddr, Pwrite, Pwdata, Pstrb, Pprot
    );
endinterface

// File: rtl/apb_master_mc.sv
// Multi-slave APB4 master: one command at a time, slave decoded from the address MSBs,
// one registered response per command (PSLVERR, decode error or ACCESS timeout).
//
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | Psel asserted, Penable low
//   ACCESS | Penable high, waiting for Pready of the selected slave or timeout
//   RESP   | rsp_valid pulse on the outputs, bus released
module apb_master_mc #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic              Pclk,
    input  logic              Presetn,
    apb_master_mc_if.master   bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state_q, state_d;

    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [SEL_W-1:0]      sel_idx_q, sel_idx_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;

    logic [SEL_W-1:0]      cmd_idx;
    logic                  dec_err;
    logic                  accept;
    logic                  sel_ready;
    logic                  sel_slverr;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  tmo_hit;

    assign cmd_idx = bus.cmd_addr[ADDR_W-1 -: SEL_W];
    assign dec_err = ({1'b0, cmd_idx} >= (SEL_W + 1)'(NUM_SLAVES));
    assign accept  = bus.cmd_valid && (state_q == IDLE);

    // Only the latched slave's return signals are ever looked at.
    always_comb begin
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_idx_q == SEL_W'(i)) begin
                sel_ready  = bus.Pready[i];
                sel_slverr = bus.Pslverr[i];
                sel_rdata  = bus.Prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Down-counter loaded with TIMEOUT; the last waiting cycle is the one seen at count 1.
    assign tmo_hit = (TIMEOUT != 0) && !sel_ready && (tmr_q == TMR_W'(1));

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = dec_err ? RESP : SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (sel_ready || tmo_hit) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        sel_idx_d     = sel_idx_q;
        tmr_d         = tmr_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        cmd_ready_d   = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (accept && dec_err) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (accept) begin
                    psel_d    = NUM_SLAVES'(1) << cmd_idx;
                    sel_idx_d = cmd_idx;
                    paddr_d   = bus.cmd_addr;
                    pwrite_d  = bus.cmd_write;
                    pprot_d   = bus.cmd_prot;
                    pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
                    pstrb_d   = bus.cmd_write ? bus.cmd_strb  : '0;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                tmr_d     = TMR_W'(TIMEOUT);
            end
            ACCESS: begin
                if (sel_ready) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_slverr;
                    rsp_rdata_d = (!pwrite_q && !sel_slverr) ? sel_rdata : '0;
                end else if (tmo_hit) begin
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (TIMEOUT != 0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            psel_q        <= '0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            sel_idx_q     <= '0;
            tmr_q         <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            sel_idx_q     <= sel_idx_d;
            tmr_q         <= tmr_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.Psel        = psel_q;
    assign bus.Penable     = penable_q;
    assign bus.Paddr       = paddr_q;
    assign bus.Pwrite      = pwrite_q;
    assign bus.Pwdata      = pwdata_q;
    assign bus.Pstrb       = pstrb_q;
    assign bus.Pprot       = pprot_q;

endmodule

// File: tb/tb_apb_master_mc.sv
// Bench for apb_master_mc: a 4-slave instance driven by directed and random commands against
// a transaction-level response model, plus a 3-slave instance for the unmapped-index decode.
module tb_apb_master_mc;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 16;

    logic Pclk    = 1'b0;
    logic Presetn = 1'b0;
    always #5 Pclk = ~Pclk;

    int n_checks = 0;
    int n_errors = 0;

    apb_master_mc_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS)) ia ();
    apb_master_mc_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(3))  ib ();

    apb_master_mc #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .SEL_W(2), .TIMEOUT(TO)) u_dut (
        .Pclk(Pclk), .Presetn(Presetn), .bus(ia)
    );
    apb_master_mc #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(3), .SEL_W(2), .TIMEOUT(TO)) u_dut3 (
        .Pclk(Pclk), .Presetn(Presetn), .bus(ib)
    );

    typedef struct packed {
        logic [31:0] cycles;
        logic        err;
        logic        tmo;
        logic [31:0] rdata;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response of one transfer: the slave holds Pready low for wait_n ACCESS cycles, then raises it.
    function automatic exp_t ref_model(input logic wr, input int wait_n, input logic slverr,
                                       input logic [31:0] rd);
        exp_t e;
        if (TO != 0 && wait_n >= TO) begin
            e.cycles = TO;
            e.err    = 1'b1;
            e.tmo    = 1'b1;
            e.rdata  = '0;
        end else begin
            e.cycles = wait_n + 1;
            e.err    = slverr;
            e.tmo    = 1'b0;
            e.rdata  = (!wr && !slverr) ? rd : 32'h0;
        end
        return e;
    endfunction

    task automatic junk_slaves();
        ia.Pready  = 4'($urandom);
        ia.Pslverr = 4'($urandom);
        ia.Prdata  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (ia.cmd_ready !== 1'b1 && guard < 100) begin
            @(negedge Pclk);
            guard++;
        end
        chk({tag, "/cmd_ready"}, 64'(ia.cmd_ready), 64'(1));
    endtask

    task automatic do_cmd(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                          input int wait_n, input logic slverr, input logic [31:0] rd);
        exp_t        e;
        int          idx;
        logic [31:0] x_wdata;
        logic [3:0]  x_strb;
        logic [3:0]  x_sel;
        e       = ref_model(wr, wait_n, slverr, rd);
        idx     = int'(addr[31:30]);
        x_wdata = wr ? wdata : 32'h0;
        x_strb  = wr ? strb : 4'h0;
        x_sel   = 4'b0001 << idx;
        wait_ready(tag);
        ia.cmd_valid = 1'b1;
        ia.cmd_write = wr;
        ia.cmd_addr  = addr;
        ia.cmd_wdata = wdata;
        ia.cmd_strb  = strb;
        ia.cmd_prot  = prot;
        junk_slaves();
        @(negedge Pclk);
        ia.cmd_valid = 1'b0;
        ia.cmd_write = 1'($urandom);
        ia.cmd_addr  = $urandom;
        ia.cmd_wdata = $urandom;
        ia.cmd_strb  = 4'($urandom);
        ia.cmd_prot  = 3'($urandom);
        chk({tag, "/setup_psel"}, 64'(ia.Psel), 64'(x_sel));
        chk({tag, "/setup_penable"}, 64'(ia.Penable), 64'(0));
        chk({tag, "/setup_paddr"}, 64'(ia.Paddr), 64'(addr));
        chk({tag, "/setup_pwrite"}, 64'(ia.Pwrite), 64'(wr));
        chk({tag, "/setup_pwdata"}, 64'(ia.Pwdata), 64'(x_wdata));
        chk({tag, "/setup_pstrb"}, 64'(ia.Pstrb), 64'(x_strb));
        chk({tag, "/setup_pprot"}, 64'(ia.Pprot), 64'(prot));
        chk({tag, "/setup_cmd_ready"}, 64'(ia.cmd_ready), 64'(0));
        junk_slaves();
        for (int k = 1; k <= int'(e.cycles); k++) begin
            @(negedge Pclk);
            chk({tag, "/acc_psel"}, 64'(ia.Psel), 64'(x_sel));
            chk({tag, "/acc_penable"}, 64'(ia.Penable), 64'(1));
            chk({tag, "/acc_paddr"}, 64'(ia.Paddr), 64'(addr));
            chk({tag, "/acc_pwrite"}, 64'(ia.Pwrite), 64'(wr));
            chk({tag, "/acc_pwdata"}, 64'(ia.Pwdata), 64'(x_wdata));
            chk({tag, "/acc_pstrb"}, 64'(ia.Pstrb), 64'(x_strb));
            chk({tag, "/acc_pprot"}, 64'(ia.Pprot), 64'(prot));
            chk({tag, "/acc_rsp_valid"}, 64'(ia.rsp_valid), 64'(0));
            junk_slaves();
            ia.Pready[idx] = (k == wait_n + 1);
            if (k == wait_n + 1) begin
                ia.Pslverr[idx]          = slverr;
                ia.Prdata[idx*DW +: DW] = rd;
            end
        end
        @(negedge Pclk);
        chk({tag, "/rsp_valid"}, 64'(ia.rsp_valid), 64'(1));
        chk({tag, "/rsp_err"}, 64'(ia.rsp_err), 64'(e.err));
        chk({tag, "/rsp_timeout"}, 64'(ia.rsp_timeout), 64'(e.tmo));
        chk({tag, "/rsp_rdata"}, 64'(ia.rsp_rdata), 64'(e.rdata));
        chk({tag, "/rsp_psel"}, 64'(ia.Psel), 64'(0));
        chk({tag, "/rsp_penable"}, 64'(ia.Penable), 64'(0));
        chk({tag, "/rsp_cmd_ready"}, 64'(ia.cmd_ready), 64'(0));
        junk_slaves();
        @(negedge Pclk);
        chk({tag, "/post_rsp_valid"}, 64'(ia.rsp_valid), 64'(0));
        chk({tag, "/post_cmd_ready"}, 64'(ia.cmd_ready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r_idx;
        int          r_wait;
        ia.cmd_valid = 1'b0; ia.cmd_write = 1'b0; ia.cmd_addr = '0;
        ia.cmd_wdata = '0;   ia.cmd_strb  = '0;   ia.cmd_prot = '0;
        ia.Pready = '0; ia.Pslverr = '0; ia.Prdata = '0;
        ib.cmd_valid = 1'b0; ib.cmd_write = 1'b0; ib.cmd_addr = '0;
        ib.cmd_wdata = '0;   ib.cmd_strb  = '0;   ib.cmd_prot = '0;
        ib.Pready  = 3'b111;
        ib.Pslverr = 3'b000;
        ib.Prdata  = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

        repeat (3) @(negedge Pclk);
        chk("reset/cmd_ready", 64'(ia.cmd_ready), 64'(1));
        chk("reset/psel", 64'(ia.Psel), 64'(0));
        chk("reset/penable", 64'(ia.Penable), 64'(0));
        chk("reset/paddr", 64'(ia.Paddr), 64'(0));
        chk("reset/rsp_valid", 64'(ia.rsp_valid), 64'(0));
        chk("reset/rsp_err", 64'(ia.rsp_err), 64'(0));
        Presetn = 1'b1;
        @(negedge Pclk);

        // Unmapped index 3 on the 3-slave instance
        chk("dec/cmd_ready", 64'(ib.cmd_ready), 64'(1));
        ib.cmd_valid = 1'b1;
        ib.cmd_addr  = 32'hC000_0000;
        @(negedge Pclk);
        ib.cmd_valid = 1'b0;
        chk("dec/rsp_valid", 64'(ib.rsp_valid), 64'(1));
        chk("dec/rsp_err", 64'(ib.rsp_err), 64'(1));
        chk("dec/rsp_rdata", 64'(ib.rsp_rdata), 64'(0));
        chk("dec/rsp_timeout", 64'(ib.rsp_timeout), 64'(0));
        chk("dec/psel", 64'(ib.Psel), 64'(0));
        chk("dec/cmd_ready_low", 64'(ib.cmd_ready), 64'(0));
        @(negedge Pclk);
        chk("dec/post_rsp_valid", 64'(ib.rsp_valid), 64'(0));
        chk("dec/post_psel", 64'(ib.Psel), 64'(0));
        chk("dec/post_cmd_ready", 64'(ib.cmd_ready), 64'(1));
        ib.cmd_valid = 1'b1;
        ib.cmd_addr  = 32'h8000_0004;
        @(negedge Pclk);
        ib.cmd_valid = 1'b0;
        chk("dec/s2_setup_psel", 64'(ib.Psel), 64'(3'b100));
        chk("dec/s2_setup_penable", 64'(ib.Penable), 64'(0));
        @(negedge Pclk);
        chk("dec/s2_acc_penable", 64'(ib.Penable), 64'(1));
        @(negedge Pclk);
        chk("dec/s2_rsp_valid", 64'(ib.rsp_valid), 64'(1));
        chk("dec/s2_rsp_rdata", 64'(ib.rsp_rdata), 64'(32'hCCCC_0002));
        chk("dec/s2_rsp_err", 64'(ib.rsp_err), 64'(0));
        chk("dec/s2_psel", 64'(ib.Psel), 64'(0));

        do_cmd("wr_s1", 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 1'b0, 32'h0);
        do_cmd("rd_s3_wait3", 1'b0, 32'hC000_0004, 32'h5555_AAAA, 4'hA, 3'b001, 3, 1'b0, 32'h1234_5678);
        do_cmd("rd_s2_slverr", 1'b0, 32'h8000_0008, 32'h0, 4'h0, 3'b000, 1, 1'b1, 32'hFFFF_0000);
        do_cmd("rd_s0_timeout", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'b100, TO, 1'b0, 32'h0BAD_0BAD);
        do_cmd("rd_s0_last_cycle", 1'b0, 32'h0000_0024, 32'h0, 4'h0, 3'b100, TO - 1, 1'b0, 32'h600D_600D);
        do_cmd("wr_s2_strb", 1'b1, 32'h8000_0100, 32'h0102_0304, 4'h5, 3'b111, 2, 1'b0, 32'h7777_7777);

        // Reset pulsed during ACCESS
        wait_ready("rst");
        ia.cmd_valid = 1'b1;
        ia.cmd_write = 1'b0;
        ia.cmd_addr  = 32'h4000_0100;
        ia.Pready    = '0;
        @(negedge Pclk);
        ia.cmd_valid = 1'b0;
        @(negedge Pclk);
        chk("rst/acc_penable", 64'(ia.Penable), 64'(1));
        chk("rst/acc_psel", 64'(ia.Psel), 64'(4'b0010));
        Presetn = 1'b0;
        #1;
        chk("rst/psel", 64'(ia.Psel), 64'(0));
        chk("rst/penable", 64'(ia.Penable), 64'(0));
        chk("rst/rsp_valid", 64'(ia.rsp_valid), 64'(0));
        ia.Pready = 4'hF;
        @(negedge Pclk);
        @(negedge Pclk);
        Presetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Pclk);
            chk("rst/no_rsp", 64'(ia.rsp_valid), 64'(0));
            chk("rst/no_psel", 64'(ia.Psel), 64'(0));
            chk("rst/cmd_ready", 64'(ia.cmd_ready), 64'(1));
        end
        do_cmd("rst/next_cmd", 1'b0, 32'h4000_0200, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'hA5A5_5A5A);

        for (int n = 0; n < 40; n++) begin
            r_idx  = 2'($urandom_range(0, 3));
            r_wait = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO + 4))
                                                 : int'($urandom_range(0, 5));
            do_cmd($sformatf("rand%0d", n), 1'($urandom), {r_idx, 30'($urandom)}, $urandom,
                   4'($urandom), 3'($urandom), r_wait, 1'($urandom_range(0, 3) == 0), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master_mc.md
Name: apb_master_mc

Overview:
- Parametrised, multi-slave APB master (APB4 feature set); next generation of the single-slave APB master.
- Accepts one command at a time over a valid/ready command port and drives the APB bus.
- Decodes the slave from the upper address bits, supports write strobes and protection, and returns one response per command.
- Returns an error on PSLVERR, on an unmapped slave, or on an access timeout.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width (multiple of 8)
NUM_SLAVES, 4, number of PSEL lines (1..16)
SEL_W, 2, address MSBs used for slave decode; must satisfy 2**SEL_W >= NUM_SLAVES
TIMEOUT, 16, max ACCESS cycles waiting for PREADY; 0 disables timeout

Ports:
Pclk  in  1  clock
Presetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  master can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  byte strobes (write only)
cmd_prot  in  3  PPROT value
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  PSLVERR, decode error or timeout
rsp_timeout  out  1  error cause was timeout
Psel  out  NUM_SLAVES  one-hot slave select
Penable  out  1  APB enable
Paddr  out  ADDR_W  APB address
Pwrite  out  1  APB direction
Pwdata  out  DATA_W  APB write data
Pstrb  out  DATA_W/8  APB strobes
Pprot  out  3  APB protection
Prdata  in  NUM_SLAVES*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W]
Pready  in  NUM_SLAVES  per-slave ready
Pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (async, Presetn=0): state IDLE; all outputs 0 except cmd_ready=1. Timeout counter cleared.
- Reset mid-transfer: Psel and Penable drop immediately; the in-flight command is lost and no response is issued.
- All APB and response outputs are registered.
- cmd_ready = 1 only in IDLE. A command is accepted when cmd_valid && cmd_ready.

State machine (IDLE, SETUP, ACCESS, RESP):
- IDLE -> SETUP on accept with a valid decode.
- IDLE -> RESP on accept with a decode error: index = cmd_addr[ADDR_W-1 -: SEL_W] >= NUM_SLAVES.
- SETUP -> ACCESS always.
- ACCESS -> RESP when Pready[idx] = 1, or on timeout.
- RESP -> IDLE always.

Cycle timing for a command accepted at edge T:
- T+1 (SETUP): Psel[idx]=1, Penable=0. Paddr, Pwrite and Pprot are loaded. Pwdata/Pstrb are loaded for writes; reads drive Pstrb=0 and Pwdata=0.
- T+2 (ACCESS): Penable=1. Paddr, Pwrite, Pwdata, Pstrb and Pprot are held stable until the transfer ends.
- At the ACCESS edge where Pready[idx]=1, the master samples Prdata[idx] and Pslverr[idx].
  - Next cycle: Psel=0, Penable=0, rsp_valid=1 for exactly one cycle.
  - rsp_err = Pslverr[idx].
  - rsp_rdata = Prdata[idx] for an error-free read, otherwise 0.
- Zero-wait access: rsp_valid at T+3, cmd_ready high again at T+4. Minimum command period is 4 cycles.
- Decode error: no Psel asserted. rsp_valid at T+1 with rsp_err=1, rsp_rdata=0.
- Unselected slaves' Pready, Pslverr and Prdata are ignored. Pready outside ACCESS is ignored.

Timeout:
- Counter clears on entering ACCESS and increments each ACCESS cycle with Pready[idx]=0.
- When it reaches TIMEOUT, the transfer aborts: Psel=0, Penable=0 next cycle, and a response issues with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- TIMEOUT=0 waits indefinitely.

Simultaneous events:
- Pready arriving on the same edge the counter reaches TIMEOUT counts as completion; no timeout is flagged.
- rsp_timeout=0 for every non-timeout response.

Test Plan:
1. Write to addr 0x4000_0010 (slave 1), wdata 0xDEADBEEF, strb 0xF, Pready[1]=1 -> Psel=0010 at T+1, Penable at T+2, Pstrb=0xF and Pwdata=0xDEADBEEF stable through ACCESS, rsp_valid at T+3 with err=0, rdata=0.
2. Read from addr 0xC000_0004 (slave 3); Pready[3] low for 3 ACCESS cycles, then high with Prdata slice 3 = 0x1234_5678 -> Paddr, Psel=1000 and Pstrb=0 held throughout, rsp_rdata=0x12345678, rsp_err=0.
3. Read from slave 2 with Pslverr[2]=1 at completion -> rsp_err=1, rsp_rdata=0, rsp_timeout=0.
4. TIMEOUT=16, Pready[0] never asserted -> exactly 16 ACCESS cycles, then Psel and Penable drop, rsp_err=1, rsp_timeout=1. Repeat with Pready[0] rising on cycle 16 -> normal completion.
5. NUM_SLAVES=3, access to addr 0xC000_0000 (index 3) -> no Psel activity, rsp_valid at T+1 with rsp_err=1.
6. Presetn pulsed low during ACCESS -> Psel, Penable and rsp_valid are 0 immediately, cmd_ready=1 after release, no response issued, and the next command completes normally.
